// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run/halt/step sequencer: FSM state encoding,
// dump index width and small state-classification helpers.
package cpu_run_ctrl_pkg;

   localparam int DUMP_IDX_W = 5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RST   = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DUMP  = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   // A fresh run (counters cleared, core re-reset) may only begin from these states.
   function automatic logic is_stopped(input state_e s);
      return (s == S_IDLE) || (s == S_DONE);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_dumper.sv
// Register-file dump engine: walks indices 0..NREGS-1 over the core test port
// and presents each word on a valid/ready stream, holding it until accepted.
module cpu_run_ctrl_dumper
   import cpu_run_ctrl_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  active_i,
   input  logic                  ready_i,
   input  logic [31:0]           rdata_i,
   output logic [DUMP_IDX_W-1:0] raddr_o,
   output logic                  valid_o,
   output logic [DUMP_IDX_W-1:0] addr_o,
   output logic [31:0]           data_o,
   output logic                  last_o,
   output logic                  done_o
);

   localparam logic [DUMP_IDX_W-1:0] LAST_IDX = DUMP_IDX_W'(NREGS - 1);

   logic [DUMP_IDX_W-1:0] idx_q, idx_d;
   logic                  fire;
   logic                  at_last;

   assign at_last = (idx_q == LAST_IDX);
   assign fire    = active_i && ready_i;

   // Index returns to zero after the final word so a later dump starts clean.
   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (fire) begin
         idx_d = at_last ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign raddr_o = idx_q;
   assign addr_o  = idx_q;
   assign data_o  = rdata_i;
   assign valid_o = active_i;
   assign last_o  = active_i && at_last;
   assign done_o  = fire && at_last;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer for the single-cycle MIPS core, with watchdog, cycle
// counter and post-run GPR dump. Define CPU_RUN_BRKPT_EN to add a PC breakpoint.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int WDOG_CYCLES = 100000,
   parameter int RST_CYCLES  = 2,
   parameter int NREGS       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  step,
   input  logic                  finish,
   input  logic [31:0]           pc,
   output logic [DUMP_IDX_W-1:0] rdtaddr,
   input  logic [31:0]           rdtdata,
   output logic                  cpu_en,
   output logic                  cpu_rst_n,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [DUMP_IDX_W-1:0] dump_addr,
   output logic [31:0]           dump_data,
   output logic                  dump_last,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic                  busy,
   output logic                  timeout
`ifdef CPU_RUN_BRKPT_EN
   ,
   input  logic [31:0]           brk_addr,
   input  logic                  brk_en,
   output logic                  brk_hit
`endif
);

   localparam int               RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);
   localparam bit               WDOG_EN   = (WDOG_CYCLES != 0);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

   state_e           state_q, state_d;
   logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             step_pend_q, step_pend_d;

   logic             start_fresh;
   logic             wdog_hit;
   logic             brk_stop;
   logic             dump_active;
   logic             dump_done;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign start_fresh = start && is_stopped(state_q);
   // The cycle that trips the watchdog still executes, so the count lands on WDOG_CYCLES.
   assign wdog_hit    = WDOG_EN && !finish && (cnt_q == WDOG_LAST);

`ifdef CPU_RUN_BRKPT_EN
   logic brk_hit_q, brk_hit_d;
   logic brk_skip_q, brk_skip_d;
   logic resume;

   // Skip lets a resumed run execute the breakpoint instruction once before re-arming.
   assign brk_stop = brk_en && (pc == brk_addr) && !finish && !brk_skip_q && !wdog_hit;
   assign resume   = (state_q == S_PAUSE) && (state_d == S_RUN);

   always_comb begin
      brk_hit_d = brk_hit_q;
      if (start_fresh || resume) begin
         brk_hit_d = 1'b0;
      end else if ((state_q == S_RUN) && brk_stop) begin
         brk_hit_d = 1'b1;
      end
      brk_skip_d = 1'b0;
      if (resume) begin
         brk_skip_d = 1'b1;
      end else if ((state_q == S_RUN) && !cpu_en) begin
         brk_skip_d = brk_skip_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brk_hit_q  <= 1'b0;
         brk_skip_q <= 1'b0;
      end else begin
         brk_hit_q  <= brk_hit_d;
         brk_skip_q <= brk_skip_d;
      end
   end

   assign brk_hit = brk_hit_q;
`else
   logic unused_pc;
   assign unused_pc = ^pc;
   assign brk_stop  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
         step_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
         step_pend_q <= step_pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RST;
         S_RST:   if (rst_cnt_q == RST_LAST) state_d = S_RUN;
         S_RUN: begin
            if (finish || wdog_hit) begin
               state_d = S_DUMP;
            end else if (brk_stop || halt_req) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (finish) begin
               state_d = S_DUMP;
            end else if (start) begin
               state_d = S_RUN;
            end
         end
         S_DUMP:  if (dump_done) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RST;
         default: state_d = S_IDLE;
      endcase
   end

   // Core enable is combinational on finish so the finish-address instruction never runs.
   always_comb begin
      cpu_en      = 1'b0;
      cpu_rst_n   = 1'b1;
      busy        = 1'b1;
      dump_active = 1'b0;
      case (state_q)
         S_IDLE: begin
            cpu_rst_n = 1'b0;
            busy      = 1'b0;
         end
         S_RST:   cpu_rst_n = 1'b0;
         S_RUN:   cpu_en = !finish && !brk_stop;
         S_PAUSE: cpu_en = step_pend_q && !finish;
         S_DUMP:  dump_active = 1'b1;
         S_DONE:  busy = 1'b0;
         default: busy = 1'b0;
      endcase
   end

   // A step is captured once; a second step while one is pending is dropped.
   always_comb begin
      rst_cnt_d = (state_q == S_RST) ? rst_cnt_q + 1'b1 : '0;

      cnt_d = cnt_q;
      if (start_fresh) begin
         cnt_d = '0;
      end else if (cpu_en) begin
         cnt_d = sat_inc(cnt_q);
      end

      timeout_d = timeout_q;
      if (start_fresh) begin
         timeout_d = 1'b0;
      end else if ((state_q == S_RUN) && wdog_hit) begin
         timeout_d = 1'b1;
      end

      step_pend_d = (state_q == S_PAUSE) && step && !step_pend_q && !start && !finish;
   end

   cpu_run_ctrl_dumper #(
      .NREGS (NREGS)
   ) u_dumper (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .clr_i    (start_fresh),
      .active_i (dump_active),
      .ready_i  (dump_ready),
      .rdata_i  (rdtdata),
      .raddr_o  (rdtaddr),
      .valid_o  (dump_valid),
      .addr_o   (dump_addr),
      .data_o   (dump_data),
      .last_o   (dump_last),
      .done_o   (dump_done)
   );

   assign cycle_cnt = cnt_q;
   assign timeout   = timeout_q;

endmodule
